// File: rtl/adder_arbiter.sv
// Round-robin front end that time-shares one external W-bit adder among NREQ requesters.
// Operands are latched on accept; the sum comes back on a held valid/ready channel tagged by id.
module adder_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 32,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   input  logic [W-1:0]      add_out,
   input  logic              add_carry,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_sum,
   output logic              rsp_carry,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] id;
   logic           grant_vld;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] scan_idx;
   logic [W-1:0]   a_arr [NREQ];
   logic [W-1:0]   b_arr [NREQ];

   // Unpack the flat operand buses into per-requester lanes.
   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         a_arr[i] = req_a[i*W +: W];
         b_arr[i] = req_b[i*W +: W];
      end
   end

   // Scan starting at ptr; the first valid requester found wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = IDW'((32'(ptr) + k) % NREQ);
         if (!grant_vld && req_valid[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && (state == IDLE) && grant_vld) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         id        <= '0;
         add_a     <= '0;
         add_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  add_a <= a_arr[grant_idx];
                  add_b <= b_arr[grant_idx];
                  id    <= grant_idx;
                  state <= ISSUE;
                  busy  <= 1'b1;
               end
            end
            ISSUE: begin
               rsp_sum   <= add_out;
               rsp_carry <= add_carry;
               rsp_id    <= id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               // Pointer moves past the served requester only once its result is taken.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= IDW'((32'(id) + 1) % NREQ);
                  state     <= IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_adder_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 32;
   localparam int unsigned IDW  = 2;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [W-1:0]      add_a;
   logic [W-1:0]      add_b;
   logic [W-1:0]      add_out;
   logic              add_carry;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_sum;
   logic              rsp_carry;
   logic              busy;

   int checks = 0;
   int errors = 0;

   adder_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .add_a(add_a), .add_b(add_b),
      .add_out(add_out), .add_carry(add_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
      .busy(busy)
   );

   // The shared adder the block sits in front of.
   always_comb {add_carry, add_out} = {1'b0, add_a} + {1'b0, add_b};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   // Transaction model: phase 0 idle, 1 operands at adder, 2 response held.
   bit          m_ok = 0;
   int          m_ph, m_ptr, m_id, m_g;
   logic [31:0] m_a, m_b, m_rsum;
   logic        m_rcar, m_rv;
   int          m_rid;
   logic [3:0]  m_rdy;

   always @(negedge clk) begin
      m_g = -1;
      if (m_ok && !rst && m_ph == 0) begin
         for (int k = 0; k < NREQ; k++) begin
            if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
         end
      end
      m_rdy = 4'b0000;
      if (m_g >= 0) m_rdy[m_g] = 1'b1;
      if (m_ok) begin
         chk("model_req_ready", 64'(req_ready), 64'(m_rdy));
         chk("model_busy", 64'(busy), 64'(m_ph != 0));
         chk("model_add_a", 64'(add_a), 64'(m_a));
         chk("model_add_b", 64'(add_b), 64'(m_b));
         chk("model_rsp_valid", 64'(rsp_valid), 64'(m_rv));
         chk("model_rsp_id", 64'(rsp_id), 64'(m_rid));
         chk("model_rsp_sum", 64'(rsp_sum), 64'(m_rsum));
         chk("model_rsp_carry", 64'(rsp_carry), 64'(m_rcar));
      end
      if (rst === 1'b1) begin
         m_ok = 1; m_ph = 0; m_ptr = 0; m_id = 0;
         m_a = 0; m_b = 0; m_rsum = 0; m_rcar = 0; m_rv = 0; m_rid = 0;
      end else if (m_ok) begin
         case (m_ph)
            0: if (m_g >= 0) begin
               m_a  = req_a[m_g*W +: W];
               m_b  = req_b[m_g*W +: W];
               m_id = m_g;
               m_ph = 1;
            end
            1: begin
               {m_rcar, m_rsum} = 33'(m_a) + 33'(m_b);
               m_rid = m_id;
               m_rv  = 1;
               m_ph  = 2;
            end
            default: if (rsp_ready) begin
               m_rv  = 0;
               m_ptr = (m_id + 1) % NREQ;
               m_ph  = 0;
            end
         endcase
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
   endtask

   task automatic wait_rsp(input string nm);
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_rsp_arrived"}, 64'(rsp_valid), 64'd1);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      @(negedge clk);
      while (busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_idle"}, 64'(busy), 64'd0);
   endtask

   // Single requester op with an accept-to-response latency of two edges.
   task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] es, input logic ec, input string nm);
      cyc();
      req_valid = '0;
      req_valid[idx] = 1'b1;
      set_ops(idx, a, b);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_ready"}, 64'(req_ready), 64'(1 << idx));
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk({nm, "_issue_no_rsp"}, 64'(rsp_valid), 64'd0);
      chk({nm, "_issue_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
      chk({nm, "_rsp_id"}, 64'(rsp_id), 64'(idx));
      chk({nm, "_rsp_sum"}, 64'(rsp_sum), 64'(es));
      chk({nm, "_rsp_carry"}, 64'(rsp_carry), 64'(ec));
      cyc();
   endtask

   int  grants[$];
   bit  seen3;

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      req_a     = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      req_b     = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};

      // Reset held with every requester valid.
      @(negedge clk);
      @(negedge clk);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_add_a", 64'(add_a), 64'd0);
      chk("reset_add_b", 64'(add_b), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      cyc();
      rst       = 1'b0;
      req_valid = '0;

      do_op(0, 32'h5555_5555, 32'h0101_0101, 32'h5656_5656, 1'b0, "single");
      do_op(2, 32'h5555_5555, 32'hABAB_ABAB, 32'h0101_0100, 1'b1, "carry");
      do_op(2, 32'h9999_9999, 32'h6666_6666, 32'hFFFF_FFFF, 1'b0, "nocarry");

      // Round robin from a fresh pointer with everyone valid.
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      set_ops(0, 32'h0000_0001, 32'h0000_0002);
      set_ops(1, 32'h0000_0010, 32'h0000_0020);
      set_ops(2, 32'hFFFF_FFFF, 32'h0000_0001);
      set_ops(3, 32'h9999_9999, 32'h6767_6767);
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      grants.delete();
      seen3 = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
         if (rsp_valid && rsp_id == 2'd3 && !seen3) begin
            seen3 = 1;
            chk("rr_req3_sum", 64'(rsp_sum), 64'h0101_0100);
            chk("rr_req3_carry", 64'(rsp_carry), 64'd1);
         end
      end
      cyc();
      req_valid = '0;
      chk("rr_req3_seen", 64'(seen3), 64'd1);
      chk("rr_grant_count_ge5", 64'(grants.size() >= 5), 64'd1);
      if (grants.size() >= 5) begin
         chk("rr_grant0", 64'(grants[0]), 64'd0);
         chk("rr_grant1", 64'(grants[1]), 64'd1);
         chk("rr_grant2", 64'(grants[2]), 64'd2);
         chk("rr_grant3", 64'(grants[3]), 64'd3);
         chk("rr_grant4", 64'(grants[4]), 64'd0);
      end
      wait_idle("rr");

      // Backpressure: hold the response for 10 cycles while others wait.
      cyc();
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      set_ops(1, 32'h1234_5678, 32'h1111_1111);
      @(negedge clk);
      chk("bp_ready", 64'(req_ready), 64'b0010);
      cyc();
      req_valid = 4'b1101;
      wait_rsp("bp");
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_stall_valid", 64'(rsp_valid), 64'd1);
         chk("bp_stall_id", 64'(rsp_id), 64'd1);
         chk("bp_stall_sum", 64'(rsp_sum), 64'h2345_6789);
         chk("bp_stall_carry", 64'(rsp_carry), 64'd0);
         chk("bp_stall_req_ready", 64'(req_ready), 64'd0);
         chk("bp_stall_busy", 64'(busy), 64'd1);
      end
      cyc();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_before_handshake", 64'(rsp_valid), 64'd1);
      @(negedge clk);
      chk("bp_after_valid", 64'(rsp_valid), 64'd0);
      chk("bp_after_busy", 64'(busy), 64'd0);
      chk("bp_next_grant", 64'(req_ready), 64'b0100);
      cyc();
      req_valid = '0;
      wait_idle("bp");

      // Reset while the operands sit at the adder.
      cyc();
      req_valid = 4'b1000;
      @(negedge clk);
      chk("rst_issue_ready", 64'(req_ready), 64'b1000);
      cyc();
      rst       = 1'b1;
      req_valid = '0;
      cyc();
      rst       = 1'b0;
      req_valid = 4'hF;
      @(negedge clk);
      chk("rst_issue_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_issue_busy", 64'(busy), 64'd0);
      chk("rst_issue_grant0", 64'(req_ready), 64'b0001);
      cyc();
      req_valid = '0;
      wait_idle("rst_issue");

      // Reset while a response is stalled.
      cyc();
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      @(negedge clk);
      chk("rst_resp_ready", 64'(req_ready), 64'b0100);
      cyc();
      req_valid = '0;
      wait_rsp("rst_resp");
      cyc();
      rst = 1'b1;
      cyc();
      rst       = 1'b0;
      req_valid = 4'hF;
      @(negedge clk);
      chk("rst_resp_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_resp_busy", 64'(busy), 64'd0);
      chk("rst_resp_grant0", 64'(req_ready), 64'b0001);
      cyc();
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle("rst_resp");

      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
